// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: keymap entry layout,
// joystick-style button indices and the power-on default keymap.
package arcade_input_pkg;

  localparam int ENT_W        = 7;
  localparam int ENT_VALID    = 6;
  localparam int ENT_PLR_LSB  = 4;
  localparam int ENT_BTN_LSB  = 0;
  localparam int KEYMAP_DEPTH = 512;

  localparam logic [3:0] BTN_RIGHT  = 4'd0;
  localparam logic [3:0] BTN_LEFT   = 4'd1;
  localparam logic [3:0] BTN_DOWN   = 4'd2;
  localparam logic [3:0] BTN_UP     = 4'd3;
  localparam logic [3:0] BTN_FIRE1  = 4'd4;
  localparam logic [3:0] BTN_FIRE2  = 4'd5;
  localparam logic [3:0] BTN_START1 = 4'd8;
  localparam logic [3:0] BTN_START2 = 4'd9;

  typedef enum logic {
    MAP_INIT = 1'b0,
    MAP_RUN  = 1'b1
  } map_state_e;

  function automatic logic [ENT_W-1:0] make_entry(input logic [1:0] plr, input logic [3:0] b);
    return {1'b1, plr, b};
  endfunction

  // Scancodes are the 9-bit {extended, code} values used as keymap addresses.
  function automatic logic [ENT_W-1:0] default_entry(input logic [8:0] code, input logic [3:0] coin_bit);
    logic [ENT_W-1:0] e;
    e = '0;
    case (code)
      9'h075:         e = make_entry(2'd0, BTN_UP);
      9'h072:         e = make_entry(2'd0, BTN_DOWN);
      9'h06B:         e = make_entry(2'd0, BTN_LEFT);
      9'h074:         e = make_entry(2'd0, BTN_RIGHT);
      9'h014:         e = make_entry(2'd0, BTN_FIRE1);
      9'h011:         e = make_entry(2'd0, BTN_FIRE2);
      9'h005, 9'h016: e = make_entry(2'd0, BTN_START1);
      9'h006, 9'h01E: e = make_entry(2'd0, BTN_START2);
      9'h076, 9'h02E: e = make_entry(2'd0, coin_bit);
      9'h02D:         e = make_entry(2'd1, BTN_UP);
      9'h02B:         e = make_entry(2'd1, BTN_DOWN);
      9'h023:         e = make_entry(2'd1, BTN_LEFT);
      9'h034:         e = make_entry(2'd1, BTN_RIGHT);
      9'h01C:         e = make_entry(2'd1, BTN_FIRE1);
      9'h036:         e = make_entry(2'd1, coin_bit);
      default:        e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/input_pulse_shaper.sv
// Per-button output shaping: coin pulse stretching or autofire gating,
// with a registered output. One down-counter serves whichever mode applies.
module input_pulse_shaper #(
  parameter bit IS_COIN  = 1'b0,
  parameter int COIN_MIN = 384000,
  parameter int AF_HALF  = 1200000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  input  logic af_en,
  output logic out
);

  localparam int CNT_W = IS_COIN ? ($clog2(COIN_MIN) + 1) : ($clog2(AF_HALF) + 1);
  localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_MIN - 1);
  localparam logic [CNT_W-1:0] AF_LOAD   = CNT_W'(AF_HALF - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;
  logic             raw_prev_reg;
  logic             out_reg, out_next;
  logic             rise;

  assign rise = raw & ~raw_prev_reg;

  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    out_next   = raw;
    if (IS_COIN) begin
      if (rise)
        cnt_next = COIN_LOAD;
      else if (cnt_reg != '0)
        cnt_next = cnt_reg - CNT_W'(1);
      out_next = raw | (cnt_reg != '0);
    end else if (af_en && raw) begin
      // The counter holds the cycles left in the current phase.
      if (rise) begin
        phase_next = 1'b1;
        cnt_next   = AF_LOAD;
        out_next   = 1'b1;
      end else if (cnt_reg == '0) begin
        phase_next = ~phase_reg;
        cnt_next   = AF_LOAD;
        out_next   = ~phase_reg;
      end else begin
        cnt_next = cnt_reg - CNT_W'(1);
        out_next = phase_reg;
      end
    end else begin
      phase_next = 1'b0;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      phase_reg    <= 1'b0;
      raw_prev_reg <= 1'b0;
      out_reg      <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
      raw_prev_reg <= raw;
      out_reg      <= out_next;
    end
  end

  assign out = out_reg;

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events and joystick words onto per-player arcade buttons,
// using a reloadable 512-entry keymap initialised from a default table.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NPLAYER  = 2,
  parameter int NBTN     = 12,
  parameter int COIN_BIT = 10,
  parameter int COIN_MIN = 384000,
  parameter int AF_HALF  = 1200000
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [10:0]             ps2_key,
  input  logic [NPLAYER*16-1:0]   joy,
  input  logic                    map_wr,
  input  logic [8:0]              map_addr,
  input  logic [6:0]              map_data,
  input  logic [NPLAYER*NBTN-1:0] af_mask,
  output logic                    map_busy,
  output logic [NPLAYER*NBTN-1:0] btn,
  output logic [NBTN-1:0]         btn_any
);

  localparam logic [3:0] COIN_IDX = 4'(COIN_BIT);

  map_state_e             state_reg, state_next;
  logic [8:0]             init_addr_reg, init_addr_next;
  logic                   ram_we;
  logic [8:0]             ram_waddr;
  logic [ENT_W-1:0]       ram_wdata;
  logic [ENT_W-1:0]       keymap [KEYMAP_DEPTH];
  logic [ENT_W-1:0]       rd_data_reg;
  logic                   tog_prev_reg;
  logic                   ev_reg;
  logic                   pressed_reg;
  logic                   key_event;
  logic [1:0]             ent_plr;
  logic [3:0]             ent_btn;
  logic                   ent_hit;
  logic [NPLAYER*NBTN-1:0] kb_reg, kb_next;
  logic [NPLAYER*NBTN-1:0] raw;

  always_comb begin
    state_next     = state_reg;
    init_addr_next = init_addr_reg;
    ram_we         = 1'b0;
    ram_waddr      = map_addr;
    ram_wdata      = map_data;
    map_busy       = 1'b0;
    case (state_reg)
      MAP_INIT: begin
        map_busy       = 1'b1;
        ram_we         = 1'b1;
        ram_waddr      = init_addr_reg;
        ram_wdata      = default_entry(init_addr_reg, COIN_IDX);
        init_addr_next = init_addr_reg + 9'd1;
        if (init_addr_reg == 9'h1FF)
          state_next = MAP_RUN;
      end
      default: ram_we = map_wr;
    endcase
  end

  // Registered read sees the old contents on a same-address write.
  always_ff @(posedge clk_sys) begin
    if (ram_we)
      keymap[ram_waddr] <= ram_wdata;
    rd_data_reg <= keymap[ps2_key[8:0]];
  end

  assign key_event = ps2_key[10] ^ tog_prev_reg;
  assign ent_plr   = rd_data_reg[ENT_PLR_LSB +: 2];
  assign ent_btn   = rd_data_reg[ENT_BTN_LSB +: 4];
  assign ent_hit   = ev_reg && rd_data_reg[ENT_VALID]
                     && (int'(ent_plr) < NPLAYER) && (int'(ent_btn) < NBTN);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg     <= MAP_INIT;
      init_addr_reg <= '0;
      tog_prev_reg  <= 1'b0;
      ev_reg        <= 1'b0;
      pressed_reg   <= 1'b0;
      kb_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      init_addr_reg <= init_addr_next;
      tog_prev_reg  <= ps2_key[10];
      ev_reg        <= key_event && (state_reg == MAP_RUN);
      pressed_reg   <= ps2_key[9];
      kb_reg        <= kb_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPLAYER * NBTN; gi++) begin : g_btn
      localparam int P = gi / NBTN;
      localparam int B = gi % NBTN;

      // The shaper sees the key bit as it is being updated so btn lags the event by two cycles.
      assign kb_next[gi] = (ent_hit && int'(ent_plr) == P && int'(ent_btn) == B)
                           ? pressed_reg : kb_reg[gi];
      assign raw[gi]     = kb_next[gi] | joy[P*16 + B];

      input_pulse_shaper #(
        .IS_COIN (B == COIN_BIT),
        .COIN_MIN(COIN_MIN),
        .AF_HALF (AF_HALF)
      ) u_shaper (
        .clk_sys(clk_sys),
        .reset  (reset),
        .raw    (raw[gi]),
        .af_en  (af_mask[gi]),
        .out    (btn[gi])
      );
    end

    for (gi = 0; gi < NPLAYER; gi++) begin : g_spare
      logic spare_unused;
      assign spare_unused = ^joy[gi*16 +: 16];
    end
  endgenerate

  always_comb begin
    btn_any = '0;
    for (int p = 0; p < NPLAYER; p++)
      btn_any = btn_any | btn[p*NBTN +: NBTN];
  end

endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 Parameter NPLAYER, default 2, number of players (1..4).
REQ-002 Parameter NBTN, default 12, buttons per player (4..16), bit order as joystick: 0 right, 1 left, 2 down, 3 up, 4.. fire/start/coin.
REQ-003 Parameter COIN_BIT, default 10, button index treated as coin.
REQ-004 Parameter COIN_MIN, default 384000, minimum coin pulse length in clk_sys cycles (16 ms at 24 MHz).
REQ-005 Parameter AF_HALF, default 1200000, autofire half-period in clk_sys cycles.
REQ-006 clk_sys  in  1  sole clock; one clock; all logic on its rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 ps2_key  in  11  [10] toggle strobe, [9] pressed, [8:0] extended+scancode.
REQ-009 joy  in  NPLAYER*16  per-player joystick words, player p at [p*16+15:p*16], active-high.
REQ-010 map_wr  in  1  keymap write strobe.
REQ-011 map_addr  in  9  keymap entry index (= ps2_key[8:0]).
REQ-012 map_data  in  7  entry {valid, player[1:0], button[3:0]}.
REQ-013 af_mask  in  NPLAYER*NBTN  per-button autofire enable.
REQ-014 map_busy  out  1  high during keymap initialisation.
REQ-015 btn  out  NPLAYER*NBTN  final per-player buttons, active-high, player p at [p*NBTN+NBTN-1:p*NBTN].
REQ-016 btn_any  out  NBTN  bitwise OR of btn across players.

Function
REQ-017 Keymap shall be a 512x7 RAM; after reset an INIT state shall write all 512 entries from a built-in default table, one per cycle, addresses 0..511, then enter RUN.
REQ-018 Default table: arrows 0x75/0x72/0x6B/0x74 -> P0 up/down/left/right; 0x14 -> P0 btn4; 0x11 -> P0 btn5; 0x05/0x16 -> P0 btn8; 0x06/0x1E -> P0 btn9; 0x76/0x2E -> P0 COIN_BIT; R/F/D/G -> P1 up/down/left/right; A -> P1 btn4; 0x36 -> P1 COIN_BIT; all others invalid; entries naming player >= NPLAYER or button >= NBTN shall be stored but ignored on use.
REQ-019 map_busy shall be 1 in INIT, 0 in RUN; map_wr in INIT shall be ignored; in RUN, map_wr shall write map_data at map_addr in the same cycle.
REQ-020 A key event is a change of ps2_key[10] versus its registered previous value; events in INIT shall be dropped.
REQ-021 Key pipeline: event cycle N registers code/pressed and reads RAM; cycle N+1 sets/clears the mapped key-button bit; btn reflects it at N+2.
REQ-022 A map_wr to the same address in cycle N shall not affect the event read in N (read-before-write).
REQ-023 Raw button = key-button bit OR joy bit b (b < 16).
REQ-024 Coin: rising edge of raw coin starts a per-player counter; output coin bit = raw OR (counter != 0); counter loads COIN_MIN-1 and counts down to 0; a new edge while counting reloads.
REQ-025 Autofire: for bits with af_mask set, while raw held, output is 1 for AF_HALF cycles, 0 for AF_HALF, repeating, first phase asserted on the press cycle; release forces 0 and resets phase; one shared counter per player-button; COIN_BIT ignores af_mask.
REQ-026 btn shall be registered; btn_any combinational from btn.
REQ-027 Counter widths shall be $clog2 of their parameter plus one; no wrap beyond zero.

Reset
REQ-028 On reset: btn=0, key-button bits=0, coin and autofire counters=0, previous toggle register = 0, state = INIT, map_busy=1 on first cycle after release.
REQ-029 Reset asserted mid-INIT or mid-RUN shall restart INIT from address 0 and discard any user keymap writes.

Structure
REQ-030 Package arcade_input_pkg shall hold the entry field positions, button index constants and the default-table function.
REQ-031 One sub-module, input_pulse_shaper (coin stretch + autofire per bit), instantiated NPLAYER*NBTN times via generate.

Verification
REQ-032 Reset release -> map_busy high exactly 512 cycles, then 0; btn stays 0.
REQ-033 RUN, ps2_key toggle with pressed=1 code 0x6B -> btn[1]=1 two cycles later; toggle pressed=0 -> btn[1]=0 two cycles later.
REQ-034 map_wr addr 0x29 data {1,01,0100}, then press 0x29 -> btn[NBTN+4]=1; same event in INIT -> no change.
REQ-035 joy[10] pulse 1 cycle -> btn[10] high exactly COIN_MIN cycles; second pulse at COIN_MIN/2 -> high until COIN_MIN after second edge.
REQ-036 af_mask[4]=1, joy[4] held 5*AF_HALF cycles -> btn[4] pattern 1,0,1,0,1 per AF_HALF; release -> 0 next cycle.
REQ-037 Reset asserted during autofire and after custom map write -> all btn 0, INIT reruns, 0x29 reverts to invalid.
